// File: rtl/mem_load_sequencer.sv
// Power-up loader: streams CNN weights then the image into the CNN memory (single write port)
// and, independently, FC weights into the FC memory. Writes lag the accepting handshake by one
// cycle; per-region done flags rise together with the final write of each region.
module mem_load_sequencer #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned CNN_WORDS = 50704,
  parameter int unsigned IMG_WORDS = 1024,
  parameter int unsigned FC_WORDS  = 11218,
  parameter int unsigned CNN_AW    = 16,
  parameter int unsigned FC_AW     = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cnn_valid,
  input  logic [DATA_W-1:0] cnn_data,
  output logic              cnn_ready,
  input  logic              img_valid,
  input  logic [DATA_W-1:0] img_data,
  output logic              img_ready,
  input  logic              fc_valid,
  input  logic [DATA_W-1:0] fc_data,
  output logic              fc_ready,
  output logic              cnn_mem_we,
  output logic [CNN_AW-1:0] cnn_mem_addr,
  output logic [DATA_W-1:0] cnn_mem_din,
  output logic              fc_mem_we,
  output logic [FC_AW-1:0]  fc_mem_addr,
  output logic [DATA_W-1:0] fc_mem_din,
  output logic              done_cnn,
  output logic              done_img,
  output logic              done_fc,
  output logic              busy,
  output logic              all_done
);

  typedef enum logic [1:0] {StIdle, StLoadCnn, StLoadImg, StDone} cnn_state_e;
  typedef enum logic [1:0] {FcIdle, FcLoad, FcDone} fc_state_e;

  localparam logic [CNN_AW-1:0] CnnLast = CNN_AW'(CNN_WORDS - 1);
  localparam logic [CNN_AW-1:0] ImgLast = CNN_AW'(IMG_WORDS - 1);
  // Image region sits directly above the CNN weights.
  localparam logic [CNN_AW-1:0] ImgBase = CNN_AW'(CNN_WORDS);
  localparam logic [FC_AW-1:0]  FcLast  = FC_AW'(FC_WORDS - 1);

  cnn_state_e        cnn_state_q, cnn_state_d;
  fc_state_e         fc_state_q, fc_state_d;
  logic [CNN_AW-1:0] cnn_cnt_q, cnn_cnt_d;
  logic [CNN_AW-1:0] img_cnt_q, img_cnt_d;
  logic [FC_AW-1:0]  fc_cnt_q, fc_cnt_d;
  logic              cnn_we_q, cnn_we_d;
  logic [CNN_AW-1:0] cnn_addr_q, cnn_addr_d;
  logic [DATA_W-1:0] cnn_din_q, cnn_din_d;
  logic              fc_we_q, fc_we_d;
  logic [FC_AW-1:0]  fc_addr_q, fc_addr_d;
  logic [DATA_W-1:0] fc_din_q, fc_din_d;
  logic              done_cnn_q, done_cnn_d;
  logic              done_img_q, done_img_d;
  logic              done_fc_q, done_fc_d;
  logic              all_done_q, all_done_d;

  logic start_ok;
  logic cnn_xfer, img_xfer, fc_xfer;

  // Readies come from state alone so a source can never combinationally loop through us.
  assign cnn_ready = (cnn_state_q == StLoadCnn);
  assign img_ready = (cnn_state_q == StLoadImg);
  assign fc_ready  = (fc_state_q == FcLoad);
  assign busy      = cnn_ready | img_ready | fc_ready;
  assign start_ok  = start & ~busy;

  assign cnn_xfer = cnn_valid & cnn_ready;
  assign img_xfer = img_valid & img_ready;
  assign fc_xfer  = fc_valid & fc_ready;

  // CNN-port FSM: weights, then image, through the one CNN memory write port.
  always_comb begin
    cnn_state_d = cnn_state_q;
    cnn_cnt_d   = cnn_cnt_q;
    img_cnt_d   = img_cnt_q;
    cnn_we_d    = 1'b0;
    cnn_addr_d  = cnn_addr_q;
    cnn_din_d   = cnn_din_q;
    done_cnn_d  = done_cnn_q;
    done_img_d  = done_img_q;
    unique case (cnn_state_q)
      StIdle, StDone: begin
        if (start_ok) begin
          cnn_state_d = StLoadCnn;
          cnn_cnt_d   = '0;
          img_cnt_d   = '0;
          done_cnn_d  = 1'b0;
          done_img_d  = 1'b0;
        end
      end
      StLoadCnn: begin
        if (cnn_xfer) begin
          cnn_we_d   = 1'b1;
          cnn_addr_d = cnn_cnt_q;
          cnn_din_d  = cnn_data;
          cnn_cnt_d  = cnn_cnt_q + CNN_AW'(1);
          if (cnn_cnt_q == CnnLast) begin
            cnn_state_d = StLoadImg;
            done_cnn_d  = 1'b1;
          end
        end
      end
      StLoadImg: begin
        if (img_xfer) begin
          cnn_we_d   = 1'b1;
          cnn_addr_d = ImgBase + img_cnt_q;
          cnn_din_d  = img_data;
          img_cnt_d  = img_cnt_q + CNN_AW'(1);
          if (img_cnt_q == ImgLast) begin
            cnn_state_d = StDone;
            done_img_d  = 1'b1;
          end
        end
      end
      default: cnn_state_d = StIdle;
    endcase
  end

  // FC FSM: runs concurrently with and independently of the CNN-port FSM.
  always_comb begin
    fc_state_d = fc_state_q;
    fc_cnt_d   = fc_cnt_q;
    fc_we_d    = 1'b0;
    fc_addr_d  = fc_addr_q;
    fc_din_d   = fc_din_q;
    done_fc_d  = done_fc_q;
    unique case (fc_state_q)
      FcIdle, FcDone: begin
        if (start_ok) begin
          fc_state_d = FcLoad;
          fc_cnt_d   = '0;
          done_fc_d  = 1'b0;
        end
      end
      FcLoad: begin
        if (fc_xfer) begin
          fc_we_d   = 1'b1;
          fc_addr_d = fc_cnt_q;
          fc_din_d  = fc_data;
          fc_cnt_d  = fc_cnt_q + FC_AW'(1);
          if (fc_cnt_q == FcLast) begin
            fc_state_d = FcDone;
            done_fc_d  = 1'b1;
          end
        end
      end
      default: fc_state_d = FcIdle;
    endcase
  end

  // all_done lags the last done flag by one cycle and drops with the flags on a new start.
  always_comb begin
    all_done_d = start_ok ? 1'b0 : (done_cnn_q & done_img_q & done_fc_q);
  end

  // State, counters and registered memory-port outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnn_state_q <= StIdle;
      fc_state_q  <= FcIdle;
      cnn_cnt_q   <= '0;
      img_cnt_q   <= '0;
      fc_cnt_q    <= '0;
      cnn_we_q    <= 1'b0;
      cnn_addr_q  <= '0;
      cnn_din_q   <= '0;
      fc_we_q     <= 1'b0;
      fc_addr_q   <= '0;
      fc_din_q    <= '0;
      done_cnn_q  <= 1'b0;
      done_img_q  <= 1'b0;
      done_fc_q   <= 1'b0;
      all_done_q  <= 1'b0;
    end else begin
      cnn_state_q <= cnn_state_d;
      fc_state_q  <= fc_state_d;
      cnn_cnt_q   <= cnn_cnt_d;
      img_cnt_q   <= img_cnt_d;
      fc_cnt_q    <= fc_cnt_d;
      cnn_we_q    <= cnn_we_d;
      cnn_addr_q  <= cnn_addr_d;
      cnn_din_q   <= cnn_din_d;
      fc_we_q     <= fc_we_d;
      fc_addr_q   <= fc_addr_d;
      fc_din_q    <= fc_din_d;
      done_cnn_q  <= done_cnn_d;
      done_img_q  <= done_img_d;
      done_fc_q   <= done_fc_d;
      all_done_q  <= all_done_d;
    end
  end

  assign cnn_mem_we   = cnn_we_q;
  assign cnn_mem_addr = cnn_addr_q;
  assign cnn_mem_din  = cnn_din_q;
  assign fc_mem_we    = fc_we_q;
  assign fc_mem_addr  = fc_addr_q;
  assign fc_mem_din   = fc_din_q;
  assign done_cnn     = done_cnn_q;
  assign done_img     = done_img_q;
  assign done_fc      = done_fc_q;
  assign all_done     = all_done_q;

endmodule

// File: doc/mem_load_sequencer.md
Name: mem_load_sequencer

Overview:
Sequences the power-up load of CNN weights, input image and FC weights from the IO unit into the two on-chip memories. It owns the single write port of the CNN memory. It fills CNN weights first, then the image at the address directly above them, and fills the FC memory concurrently. Each source uses a valid/ready handshake; the block raises per-region done flags for the downstream compute controller.

Parameters:
DATA_W, 16, word width of all data paths
CNN_WORDS, 50704, CNN weight words; also the image base address
IMG_WORDS, 1024, image words
FC_WORDS, 11218, FC weight words
CNN_AW, 16, CNN memory address width; must hold CNN_WORDS+IMG_WORDS-1
FC_AW, 14, FC memory address width; must hold FC_WORDS-1

Ports:
clk  in  1  clock; all logic on the rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse that begins a load sequence
cnn_valid  in  1  CNN weight word available
cnn_data  in  DATA_W  CNN weight word
cnn_ready  out  1  CNN word accepted when valid&&ready
img_valid  in  1  image word available
img_data  in  DATA_W  image word
img_ready  out  1  image word accepted when valid&&ready
fc_valid  in  1  FC weight word available
fc_data  in  DATA_W  FC weight word
fc_ready  out  1  FC word accepted when valid&&ready
cnn_mem_we  out  1  CNN memory write enable
cnn_mem_addr  out  CNN_AW  CNN memory address
cnn_mem_din  out  DATA_W  CNN memory write data
fc_mem_we  out  1  FC memory write enable
fc_mem_addr  out  FC_AW  FC memory address
fc_mem_din  out  DATA_W  FC memory write data
done_cnn  out  1  all CNN weights written
done_img  out  1  all image words written
done_fc  out  1  all FC weights written
busy  out  1  any load in progress
all_done  out  1  done_cnn & done_img & done_fc

Behaviour:
- Reset (async, rst_n=0): both FSMs go to IDLE, counters to 0, and every output to 0. Reset mid-load aborts the load. Partial memory contents are left as written and are not erased.
- CNN-port FSM: IDLE -> LOAD_CNN -> LOAD_IMG -> DONE.
- FC FSM: IDLE -> LOAD_FC -> DONE.
- start is honoured only when both FSMs are in IDLE or DONE. It moves the CNN-port FSM to LOAD_CNN and the FC FSM to LOAD_FC, clears all done flags and clears all counters. start while busy=1 is ignored.
- Ready signals are decoded from state only and never depend on valid:
  - cnn_ready = (state==LOAD_CNN)
  - img_ready = (state==LOAD_IMG)
  - fc_ready = (fc_state==LOAD_FC)
- Write timing: a transfer accepted in cycle T drives we=1 with the registered addr and din in cycle T+1 (1-cycle latency).
- When no transfer occurs, we=0 the next cycle; addr and din hold their last values.
- CNN weights: address = cnn_cnt, counting 0..CNN_WORDS-1.
- Image: address = CNN_WORDS + img_cnt, with img_cnt counting 0..IMG_WORDS-1. Addition is unsigned at CNN_AW width with no wrap; the parameter constraint guarantees this.
- FC weights: address = fc_cnt, counting 0..FC_WORDS-1.
- Region end: on the transfer of the last word of a region (count==N-1 with valid&&ready), the FSM advances at that same edge. The ready for that region is therefore 0 in the next cycle, and no word beyond N is ever accepted.
- Done flags: each flag is set at the same edge that registers the last write, so it is visible together with the final we pulse. Flags hold until reset or an accepted start.
- The CNN memory write port is never shared within a cycle: image writes cannot begin before the CNN region completes. img_valid asserted early is simply stalled.
- Valid may drop at any time; the counter and address pause with no gaps written and no duplicates.
- busy = 1 whenever either FSM is in a LOAD_* state.
- all_done is registered: 1 in the cycle after the last of the three done flags sets.
- FC and CNN-port FSMs are fully independent. Simultaneous last transfers on both are each handled in the same cycle.

Test Plan:
- Params CNN_WORDS=8, IMG_WORDS=4, FC_WORDS=5; reset, start, all valids held at 1 with data=index:
  - CNN writes to addresses 0..7 in cycles 2..9.
  - Image writes to addresses 8..11 with data 0..3.
  - FC writes to addresses 0..4.
  - done_fc with the FC addr-4 write; done_img with the addr-11 write; all_done one cycle after done_img.
- img_valid=1 from start while the CNN load is running: img_ready stays 0 until the cycle after the 8th CNN accept, and no image write precedes the CNN addr-7 write.
- cnn_valid toggled 1,0,0,1,...: the address sequence is still strictly 0..7 with no repeats; cnn_mem_we=0 in the cycles following non-transfers.
- Second start pulse at the FC 2nd word: ignored. Then start after all_done: done flags clear in the next cycle and addresses restart at 0.
- rst_n pulled low after 3 CNN writes: all outputs 0 asynchronously. After release, no writes occur until start; the next sequence begins at address 0.
- Extra valid words after the region end (cnn_valid held high after 8 words): cnn_ready=0, and the CNN memory receives exactly 8 CNN weight writes.
